pipelined_rf_core: RTL and testbench

//  Parametrised 3-stage in-order core (Fetch, Decode/RF-read, Execute/Writeback) that writes results back to an

---
 rtl/pipelined_rf_core.sv | 169 ++++++++++++++++
 tb/tb_pipelined_rf_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_rf_core.sv
// Three-stage in-order core (Fetch, Decode/RF-read, Execute/Writeback) with an internal register file.
// It has an EX->D forward path (or a one-cycle RAW stall), STOP squash and a retire counter.
module pipelined_rf_core #(
   parameter int DATA_W     = 32,
   parameter int NUM_REGS   = 8,
   parameter int IMEM_DEPTH = 8,
   parameter bit FORWARD_EN = 1'b1,
   localparam int RA_W      = $clog2(NUM_REGS),
   localparam int PC_W      = $clog2(IMEM_DEPTH),
   localparam int INSTR_W   = 4 + 2 * RA_W
) (
   input  logic               clk,
   input  logic               n_reset,
   output logic [PC_W-1:0]    imem_addr_o,
   input  logic [INSTR_W-1:0] imem_data_i,
   output logic [DATA_W-1:0]  alu_result_o,
   output logic               alu_result_valid_o,
   output logic               stop_o,
   output logic               fetch_done_o,
   output logic [15:0]        retired_o
);

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_MOV  = 4'd6,
      OP_LDI  = 4'd7,
      OP_STOP = 4'd15
   } opcode_e;

   logic [PC_W-1:0]    pc_q;
   logic               fetch_done_q;
   logic               stop_q;
   logic               fd_valid_q;
   logic               fd_hold_q;
   logic [INSTR_W-1:0] fd_saved_q;
   logic               de_valid_q;
   logic [3:0]         de_op_q;
   logic [RA_W-1:0]    de_rd_q;
   logic [DATA_W-1:0]  de_a_q;
   logic [DATA_W-1:0]  de_b_q;
   logic [DATA_W-1:0]  alu_q;
   logic               alu_valid_q;
   logic [15:0]        retired_q;
   logic [DATA_W-1:0]  rf [NUM_REGS];

   logic [INSTR_W-1:0] d_instr;
   logic [3:0]         d_op;
   logic [RA_W-1:0]    d_rd;
   logic [RA_W-1:0]    d_rs;
   logic               d_reads_rd;
   logic               d_reads_rs;
   logic               ex_writes;
   logic               ex_stop;
   logic               hazard;
   logic               stall;
   logic               fwd_rd;
   logic               fwd_rs;
   logic               fetch_en;
   logic [DATA_W-1:0]  ex_result;
   logic [DATA_W-1:0]  d_a;
   logic [DATA_W-1:0]  d_b;

   always_comb begin
      // Instruction memory keeps streaming while stalled, so a stalled D stage replays its saved copy.
      d_instr    = fd_hold_q ? fd_saved_q : imem_data_i;
      d_op       = d_instr[INSTR_W-1 -: 4];
      d_rd       = d_instr[2*RA_W-1 -: RA_W];
      d_rs       = d_instr[RA_W-1:0];
      d_reads_rd = (d_op >= OP_ADD) && (d_op <= OP_XOR);
      d_reads_rs = (d_op >= OP_ADD) && (d_op <= OP_MOV);

      ex_writes  = de_valid_q && (de_op_q >= OP_ADD) && (de_op_q <= OP_LDI);
      ex_stop    = de_valid_q && (de_op_q == OP_STOP);

      ex_result = '0;
      case (de_op_q)
         OP_ADD:  ex_result = de_a_q + de_b_q;
         OP_SUB:  ex_result = de_a_q - de_b_q;
         OP_AND:  ex_result = de_a_q & de_b_q;
         OP_OR:   ex_result = de_a_q | de_b_q;
         OP_XOR:  ex_result = de_a_q ^ de_b_q;
         OP_MOV:  ex_result = de_b_q;
         OP_LDI:  ex_result = de_b_q;
         default: ex_result = '0;
      endcase

      hazard   = fd_valid_q && ex_writes &&
                 ((d_reads_rd && (d_rd == de_rd_q)) || (d_reads_rs && (d_rs == de_rd_q)));
      stall    = !FORWARD_EN && hazard && !ex_stop;
      fwd_rd   = FORWARD_EN && ex_writes && (d_rd == de_rd_q);
      fwd_rs   = FORWARD_EN && ex_writes && (d_rs == de_rd_q);

      d_a = fwd_rd ? ex_result : rf[d_rd];
      if (d_op == OP_LDI)
         d_b = {{(DATA_W-RA_W){1'b0}}, d_rs};
      else
         d_b = fwd_rs ? ex_result : rf[d_rs];

      fetch_en = !fetch_done_q && !stall && !ex_stop && !stop_q;
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         pc_q         <= '0;
         fetch_done_q <= 1'b0;
         stop_q       <= 1'b0;
         fd_valid_q   <= 1'b0;
         fd_hold_q    <= 1'b0;
         fd_saved_q   <= '0;
         de_valid_q   <= 1'b0;
         de_op_q      <= '0;
         de_rd_q      <= '0;
         de_a_q       <= '0;
         de_b_q       <= '0;
         alu_q        <= '0;
         alu_valid_q  <= 1'b0;
         retired_q    <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++)
            rf[RA_W'(i)] <= '0;
      end else begin
         if (fetch_en) begin
            if (pc_q == PC_W'(IMEM_DEPTH - 1))
               fetch_done_q <= 1'b1;
            else
               pc_q <= pc_q + PC_W'(1);
         end

         if (ex_stop || stop_q) begin
            fd_valid_q <= 1'b0;
            fd_hold_q  <= 1'b0;
         end else if (stall) begin
            fd_hold_q  <= 1'b1;
            fd_saved_q <= d_instr;
         end else begin
            fd_valid_q <= fetch_en;
            fd_hold_q  <= 1'b0;
         end

         de_valid_q <= fd_valid_q && !(ex_stop || stall || stop_q);
         de_op_q    <= d_op;
         de_rd_q    <= d_rd;
         de_a_q     <= d_a;
         de_b_q     <= d_b;

         if (ex_writes) begin
            rf[de_rd_q] <= ex_result;
            alu_q       <= ex_result;
         end
         alu_valid_q <= ex_writes;
         if (de_valid_q)
            retired_q <= retired_q + 16'd1;
         if (ex_stop)
            stop_q <= 1'b1;
      end
   end

   assign imem_addr_o        = pc_q;
   assign alu_result_o       = alu_q;
   assign alu_result_valid_o = alu_valid_q;
   assign stop_o             = stop_q;
   assign fetch_done_o       = fetch_done_q;
   assign retired_o          = retired_q;

endmodule

// File: tb/tb_pipelined_rf_core.sv
// Bench for pipelined_rf_core: a forwarding and a stalling instance run the same programs against an
// instruction-level reference model that predicts per-cycle outputs.
module tb_pipelined_rf_core;
   localparam int DW = 8;
   localparam int IW = 10;
   localparam int NC = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          n_reset;
   logic [IW-1:0] prog [8];
   logic [2:0]    addr [2];
   logic [IW-1:0] imem [2];
   logic [DW-1:0] res  [2];
   logic          vld  [2];
   logic          stp  [2];
   logic          dn   [2];
   logic [15:0]   ret  [2];

   pipelined_rf_core #(.DATA_W(DW), .NUM_REGS(8), .IMEM_DEPTH(8), .FORWARD_EN(1'b1)) dut_fwd (
      .clk(clk), .n_reset(n_reset), .imem_addr_o(addr[0]), .imem_data_i(imem[0]),
      .alu_result_o(res[0]), .alu_result_valid_o(vld[0]), .stop_o(stp[0]),
      .fetch_done_o(dn[0]), .retired_o(ret[0]));

   pipelined_rf_core #(.DATA_W(DW), .NUM_REGS(8), .IMEM_DEPTH(8), .FORWARD_EN(1'b0)) dut_stl (
      .clk(clk), .n_reset(n_reset), .imem_addr_o(addr[1]), .imem_data_i(imem[1]),
      .alu_result_o(res[1]), .alu_result_valid_o(vld[1]), .stop_o(stp[1]),
      .fetch_done_o(dn[1]), .retired_o(ret[1]));

   // Instruction memory with one-cycle read latency
   always @(posedge clk) begin
      imem[0] <= prog[addr[0]];
      imem[1] <= prog[addr[1]];
   end

   bit            exp_v   [2][NC];
   logic [DW-1:0] exp_r   [2][NC];
   bit            exp_s   [2][NC];
   bit            exp_d   [2][NC];
   int            exp_ret [2][NC];
   logic          cap_v   [2][NC];
   logic [DW-1:0] cap_r   [2][NC];
   logic          cap_s   [2][NC];
   logic          cap_d   [2][NC];
   logic [15:0]   cap_ret [2][NC];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs);
      logic [3:0] o;
      logic [2:0] d;
      logic [2:0] s;
      o = 4'(op);
      d = 3'(rd);
      s = 3'(rs);
      return {o, d, s};
   endfunction

   // Run the program sequentially; instruction i executes in cycle i+2 plus the stalls before it,
   // and its effects are visible the cycle after.
   task automatic build_model(input int m);
      logic [DW-1:0] regs [8];
      logic [DW-1:0] r;
      logic [3:0]    op;
      logic [2:0]    rd, rs, prd;
      bit            w, pw, rr, rsr;
      int            stalls, f7s, stop_ex, ec;
      for (int c = 0; c < NC; c++) begin
         exp_v[m][c] = 0; exp_r[m][c] = '0; exp_s[m][c] = 0; exp_d[m][c] = 0; exp_ret[m][c] = 0;
      end
      for (int k = 0; k < 8; k++) regs[k] = '0;
      stalls = 0; f7s = 0; stop_ex = 1000; pw = 0; prd = '0;
      for (int i = 0; i < 8; i++) begin
         op  = prog[i][9:6];
         rd  = prog[i][5:3];
         rs  = prog[i][2:0];
         rr  = (op >= 1) && (op <= 5);
         rsr = (op >= 1) && (op <= 6);
         w   = (op >= 1) && (op <= 7);
         if (m == 1 && pw && ((rr && rd == prd) || (rsr && rs == prd))) begin
            stalls++;
            if (i <= 6) f7s++;
         end
         ec = i + 2 + stalls;
         case (op)
            4'd1: r = regs[rd] + regs[rs];
            4'd2: r = regs[rd] - regs[rs];
            4'd3: r = regs[rd] & regs[rs];
            4'd4: r = regs[rd] | regs[rs];
            4'd5: r = regs[rd] ^ regs[rs];
            4'd6: r = regs[rs];
            4'd7: r = DW'(rs);
            default: r = '0;
         endcase
         for (int c = ec + 1; c < NC; c++) exp_ret[m][c]++;
         if (w) begin
            regs[rd] = r;
            if (ec + 1 < NC) begin
               exp_v[m][ec+1] = 1;
               exp_r[m][ec+1] = r;
            end
         end
         if (op == 4'd15) begin
            stop_ex = ec;
            for (int c = ec + 1; c < NC; c++) exp_s[m][c] = 1;
            break;
         end
         pw  = w;
         prd = rd;
      end
      if (7 + f7s < stop_ex)
         for (int c = 8 + f7s; c < NC; c++) exp_d[m][c] = 1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            cap_v[m][cyc] = vld[m]; cap_r[m][cyc] = res[m]; cap_s[m][cyc] = stp[m];
            cap_d[m][cyc] = dn[m];  cap_ret[m][cyc] = ret[m];
            check($sformatf("m%0d c%0d valid", m, cyc), 32'(vld[m]), 32'(exp_v[m][cyc]));
            if (exp_v[m][cyc])
               check($sformatf("m%0d c%0d result", m, cyc), 32'(res[m]), 32'(exp_r[m][cyc]));
            check($sformatf("m%0d c%0d stop", m, cyc), 32'(stp[m]), 32'(exp_s[m][cyc]));
            check($sformatf("m%0d c%0d fetch_done", m, cyc), 32'(dn[m]), 32'(exp_d[m][cyc]));
            check($sformatf("m%0d c%0d retired", m, cyc), 32'(ret[m]), 32'(exp_ret[m][cyc]));
            if (cyc == 0)
               check($sformatf("m%0d reset result", m), 32'(res[m]), 32'd0);
            if (cyc <= 1)
               check($sformatf("m%0d c%0d imem_addr", m, cyc), 32'(addr[m]), 32'(cyc));
         end
      end
   end

   // One reset edge, then ncyc checked cycles; a short run followed by another run is a mid-program reset.
   task automatic run(input int ncyc);
      build_model(0);
      build_model(1);
      @(posedge clk); #1 n_reset = 1'b0;
      @(posedge clk); #1 n_reset = 1'b1;
      chk_en = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         cyc = c;
         @(posedge clk); #1;
      end
      chk_en = 1'b0;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 8; i++) prog[i] = '0;
   endtask

   function automatic logic [IW-1:0] rand_instr();
      int r, op, hi;
      r = int'($urandom_range(0, 19));
      if (r < 2)       op = 0;
      else if (r < 16) op = 1 + (r - 2) % 7;
      else if (r < 18) op = int'($urandom_range(8, 14));
      else             op = 15;
      hi = ($urandom_range(0, 1) == 0) ? 3 : 7;
      return enc(op, int'($urandom_range(0, hi)), int'($urandom_range(0, hi)));
   endfunction

   initial begin
      n_reset = 1'b0;
      clear_prog();

      // LDI r1,5; LDI r2,3; ADD r1,r2; MOV r0,r1
      prog[0] = enc(7, 1, 5); prog[1] = enc(7, 2, 3); prog[2] = enc(1, 1, 2); prog[3] = enc(6, 0, 1);
      run(NC);
      check("p1 fwd r@3", 32'(cap_r[0][3]), 32'd5);
      check("p1 fwd r@4", 32'(cap_r[0][4]), 32'd3);
      check("p1 fwd v@5", 32'(cap_v[0][5]), 32'd1);
      check("p1 fwd r@5", 32'(cap_r[0][5]), 32'd8);
      check("p1 fwd mov r1", 32'(cap_r[0][6]), 32'd8);
      check("p1 stl r@4", 32'(cap_r[1][4]), 32'd3);
      check("p1 stl bubble v@5", 32'(cap_v[1][5]), 32'd0);
      check("p1 stl r@6", 32'(cap_r[1][6]), 32'd8);
      check("p1 stl retired@6", 32'(cap_ret[1][6]), 32'd3);

      // Same program cut short, then a fresh program after a one-cycle reset
      run(4);
      clear_prog();
      for (int i = 0; i < 8; i++) prog[i] = enc(7, i, i);
      run(NC);
      check("p4 fwd r@10", 32'(cap_r[0][10]), 32'd7);
      check("p4 fwd done@7", 32'(cap_d[0][7]), 32'd0);
      check("p4 fwd done@8", 32'(cap_d[0][8]), 32'd1);
      check("p4 fwd v@11", 32'(cap_v[0][11]), 32'd0);
      check("p4 fwd retired", 32'(cap_ret[0][NC-1]), 32'd8);
      check("p4 stl done@8", 32'(cap_d[1][8]), 32'd1);

      // LDI r3,7; LDI r4,1; SUB r4,r3; MOV r0,r4
      clear_prog();
      prog[0] = enc(7, 3, 7); prog[1] = enc(7, 4, 1); prog[2] = enc(2, 4, 3); prog[3] = enc(6, 0, 4);
      run(NC);
      check("p2 fwd sub wrap", 32'(cap_r[0][5]), 32'hFA);
      check("p2 stl bubble v@5", 32'(cap_v[1][5]), 32'd0);
      check("p2 stl sub wrap", 32'(cap_r[1][6]), 32'hFA);

      // LDI r1,2; STOP; ADD r1,r1; MOV r0,r1
      clear_prog();
      prog[0] = enc(7, 1, 2); prog[1] = enc(15, 0, 0); prog[2] = enc(1, 1, 1); prog[3] = enc(6, 0, 1);
      run(NC);
      check("p3 fwd stop@3", 32'(cap_s[0][3]), 32'd0);
      check("p3 fwd stop@4", 32'(cap_s[0][4]), 32'd1);
      check("p3 fwd add squashed", 32'(cap_v[0][5]), 32'd0);
      check("p3 fwd retired", 32'(cap_ret[0][NC-1]), 32'd2);
      check("p3 stl stop@4", 32'(cap_s[1][4]), 32'd1);

      for (int k = 0; k < 60; k++) begin
         for (int i = 0; i < 8; i++) prog[i] = rand_instr();
         run((k % 4 == 3) ? int'($urandom_range(3, 10)) : NC);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
